pixel_scan_gen: RTL and testbench

//  Raster-order pixel coordinate source feeding generate_ray's pixel_x/pixel_y inputs.

---
 rtl/pixel_scan_gen_pkg.sv | 22 ++
 rtl/pixel_scan_gen_wrap_counter.sv | 25 ++
 rtl/pixel_scan_gen.sv | 149 ++++++++++++++
 tb/tb_pixel_scan_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_scan_gen_pkg.sv
// Shared types and defaults for the pixel scan generator and the ray stage it feeds.
package pixel_scan_gen_pkg;

  localparam int DEF_PIXEL_WIDTH  = 800;
  localparam int DEF_PIXEL_HEIGHT = 600;
  localparam int DEF_COORD_W      = 10;

  typedef logic [DEF_COORD_W-1:0] coord_t;

  // Screen coordinate pair as consumed by generate_ray.
  typedef struct packed {
    coord_t x;
    coord_t y;
  } pixel_coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/pixel_scan_gen_wrap_counter.sv
// Single-step counter that returns to zero after reaching i_max.
// Purely combinational: the caller owns the register holding i_value.
module pixel_scan_gen_wrap_counter #(
  parameter int W = 10
) (
  input  logic [W-1:0] i_value,
  input  logic         i_inc,
  input  logic [W-1:0] i_max,
  output logic [W-1:0] o_next,
  output logic         o_wrap
);

  // Advance on i_inc; wrap by equality at i_max so non-power-of-two ranges work.
  always_comb begin
    o_wrap = i_inc && (i_value == i_max);
    if (o_wrap) begin
      o_next = '0;
    end else if (i_inc) begin
      o_next = i_value + W'(1);
    end else begin
      o_next = i_value;
    end
  end

endmodule

// File: rtl/pixel_scan_gen.sv
// Raster-order pixel coordinate source: x fastest, then y, one pixel per
// un-stalled cycle. Coordinates freeze while stall is high.
// Build option: define CONTINUOUS_FRAME_EN to roll straight into the next
// frame after the last pixel instead of passing through DONE.
//
// Handshake: a pixel is accepted on a posedge where pixel_valid=1 and
// stall=0; pixel_x/pixel_y/pixel_valid/frame_start are held while stall=1.
// All outputs come from registers; stall and start only reach next-state logic.
module pixel_scan_gen
  import pixel_scan_gen_pkg::*;
#(
  parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
  parameter int PIXEL_HEIGHT = DEF_PIXEL_HEIGHT,
  parameter int COORD_W      = DEF_COORD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               pixel_valid,
  output logic               frame_start,
  output logic               frame_done,
  output logic               busy,
  output scan_state_t        o_dbg_state
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(PIXEL_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(PIXEL_HEIGHT - 1);

  scan_state_t        r_state;
  scan_state_t        w_state_next;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [COORD_W-1:0] w_x_next;
  logic [COORD_W-1:0] w_y_next;
  logic               r_frame_start;
  logic               r_frame_done;
  logic               w_accept;
  logic               w_x_wrap;
  logic               w_y_wrap;
  logic               w_last;

  // pixel_valid is exactly "in SCAN", so acceptance needs only state and stall.
  assign w_accept = (r_state == SCAN) && !stall;

  pixel_scan_gen_wrap_counter #(.W(COORD_W)) u_x_cnt (
    .i_value (r_x),
    .i_inc   (w_accept),
    .i_max   (X_MAX),
    .o_next  (w_x_next),
    .o_wrap  (w_x_wrap)
  );

  // Rows advance only when the column counter wraps.
  pixel_scan_gen_wrap_counter #(.W(COORD_W)) u_y_cnt (
    .i_value (r_y),
    .i_inc   (w_x_wrap),
    .i_max   (Y_MAX),
    .o_next  (w_y_next),
    .o_wrap  (w_y_wrap)
  );

  // A row wrap can only happen on the accept of the bottom-right pixel.
  assign w_last = w_y_wrap;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start is ignored outside IDLE.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = SCAN;
        end
      end
      SCAN: begin
        if (w_last) begin
`ifdef CONTINUOUS_FRAME_EN
          w_state_next = SCAN;
`else
          w_state_next = DONE;
`endif
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Coordinate registers: step while scanning, parked at (0,0) otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_state == SCAN) begin
      r_x <= w_x_next;
      r_y <= w_y_next;
    end else begin
      r_x <= '0;
      r_y <= '0;
    end
  end

  // Frame markers: frame_start rides with (0,0) until accepted; frame_done
  // is a one-cycle pulse following the last accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= w_last;
      unique case (r_state)
        IDLE: r_frame_start <= start;
        SCAN: begin
          if (w_accept) begin
`ifdef CONTINUOUS_FRAME_EN
            r_frame_start <= w_last;
`else
            r_frame_start <= 1'b0;
`endif
          end
        end
        default: r_frame_start <= 1'b0;
      endcase
    end
  end

  // Output decode from registered state only.
  always_comb begin
    pixel_x     = r_x;
    pixel_y     = r_y;
    pixel_valid = (r_state == SCAN);
    busy        = (r_state == SCAN);
    frame_start = r_frame_start;
    frame_done  = r_frame_done;
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Testbench for pixel_scan_gen on a 4x3 frame. Follows CONTINUOUS_FRAME_EN
// when it is defined for the build.
module tb_pixel_scan_gen;
  import pixel_scan_gen_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int CW = 10;
  localparam int OW = 2 * CW + 4;

  // ---------------- clock / reset block ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          pixel_valid;
  logic          frame_start;
  logic          frame_done;
  logic          busy;
  scan_state_t   dbg_state;

  always #5 clk = ~clk;

  pixel_scan_gen #(
    .PIXEL_WIDTH  (W),
    .PIXEL_HEIGHT (H),
    .COORD_W      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stall       (stall),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // A frame is the list of pixel indices 0..N-1; pixel k sits at (k%W, k/W).
  int m_phase = 0;   // 0 idle, 1 scanning, 2 done
  int m_idx   = 0;
  bit m_fs    = 1'b0;
  bit m_fd    = 1'b0;

  function automatic logic [OW-1:0] exp_vec(input int x, input int y, input bit v,
                                            input bit fs, input bit fd, input bit b);
    return {CW'(x), CW'(y), v, fs, fd, b};
  endfunction

  function automatic logic [OW-1:0] dut_vec();
    return {pixel_x, pixel_y, pixel_valid, frame_start, frame_done, busy};
  endfunction

  function automatic logic [OW-1:0] model_vec();
    if (m_phase == 1) return exp_vec(m_idx % W, m_idx / W, 1'b1, m_fs, m_fd, 1'b1);
    return exp_vec(0, 0, 1'b0, m_fs, m_fd, 1'b0);
  endfunction

  function automatic scan_state_t model_state();
    if (m_phase == 1) return SCAN;
    if (m_phase == 2) return DONE;
    return IDLE;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit st);
    if (!r) begin
      m_phase = 0; m_idx = 0; m_fs = 1'b0; m_fd = 1'b0;
      return;
    end
    m_fd = 1'b0;
    case (m_phase)
      0: if (s) begin m_phase = 1; m_idx = 0; m_fs = 1'b1; end
      1: if (!st) begin
           m_fs = 1'b0;
           if (m_idx == N - 1) begin
             m_idx = 0;
             m_fd  = 1'b1;
`ifdef CONTINUOUS_FRAME_EN
             m_fs  = 1'b1;
`else
             m_phase = 2;
`endif
           end else begin
             m_idx++;
           end
         end
      default: m_phase = 0;
    endcase
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    logic [OW-1:0] a;
    logic [OW-1:0] e;
    a = act;
    e = exp;
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s @%0t: got x=%0d y=%0d v=%0b fs=%0b fd=%0b busy=%0b, want x=%0d y=%0d v=%0b fs=%0b fd=%0b busy=%0b",
               name, $time, a[OW-1 -: CW], a[CW+3 -: CW], a[3], a[2], a[1], a[0],
               e[OW-1 -: CW], e[CW+3 -: CW], e[3], e[2], e[1], e[0]);
    end
  endtask

  task automatic check_model(input string name);
    compare(name, dut_vec(), model_vec());
    n_vec++;
    if (dbg_state !== model_state()) begin
      n_err++;
      $display("FAIL %s_state @%0t: got %s, want %s", name, $time,
               dbg_state.name(), model_state().name());
    end
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge, let the model see the same rising edge,
  // and leave the caller 1 time unit after it to sample.
  task automatic apply(input bit r, input bit s, input bit st);
    @(negedge clk);
    rst_n = r;
    start = s;
    stall = st;
    @(posedge clk);
    model_step(r, s, st);
    #1;
  endtask

  typedef struct {
    bit            rst_n;
    bit            start;
    bit            stall;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Reset held with start high, one full frame, then idle.
    tbl.push_back('{1'b0, 1'b1, 1'b0, exp_vec(0, 0, 1'b0, 1'b0, 1'b0, 1'b0)});
    tbl.push_back('{1'b0, 1'b1, 1'b0, exp_vec(0, 0, 1'b0, 1'b0, 1'b0, 1'b0)});
    tbl.push_back('{1'b1, 1'b1, 1'b0, exp_vec(0, 0, 1'b1, 1'b1, 1'b0, 1'b1)});
    for (int i = 1; i < N; i++)
      tbl.push_back('{1'b1, 1'b0, 1'b0, exp_vec(i % W, i / W, 1'b1, 1'b0, 1'b0, 1'b1)});
`ifdef CONTINUOUS_FRAME_EN
    tbl.push_back('{1'b1, 1'b0, 1'b0, exp_vec(0, 0, 1'b1, 1'b1, 1'b1, 1'b1)});
    tbl.push_back('{1'b1, 1'b0, 1'b0, exp_vec(1, 0, 1'b1, 1'b0, 1'b0, 1'b1)});
`else
    tbl.push_back('{1'b1, 1'b0, 1'b0, exp_vec(0, 0, 1'b0, 1'b0, 1'b1, 1'b0)});
    tbl.push_back('{1'b1, 1'b0, 1'b0, exp_vec(0, 0, 1'b0, 1'b0, 1'b0, 1'b0)});
`endif

    foreach (tbl[i]) begin
      apply(tbl[i].rst_n, tbl[i].start, tbl[i].stall);
      compare($sformatf("table[%0d]", i), dut_vec(), tbl[i].exp);
    end

    // Return to idle before the hand sequences.
    apply(1'b0, 1'b0, 1'b0);
    check_model("reset_again");
    apply(1'b1, 1'b0, 1'b0);
    check_model("idle");

    // start and stall together in IDLE: (0,0) appears and holds with frame_start.
    apply(1'b1, 1'b1, 1'b1);
    compare("start_stall_first", dut_vec(), exp_vec(0, 0, 1'b1, 1'b1, 1'b0, 1'b1));
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b0, 1'b1);
      compare("origin_hold", dut_vec(), exp_vec(0, 0, 1'b1, 1'b1, 1'b0, 1'b1));
    end
    apply(1'b1, 1'b0, 1'b0);
    compare("origin_accepted", dut_vec(), exp_vec(1, 0, 1'b1, 1'b0, 1'b0, 1'b1));
    apply(1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    check_model("reach_3_0");

    // Row wrap under stall.
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 1'b1);
      compare("hold_3_0", dut_vec(), exp_vec(3, 0, 1'b1, 1'b0, 1'b0, 1'b1));
    end
    apply(1'b1, 1'b0, 1'b0);
    compare("wrap_to_0_1", dut_vec(), exp_vec(0, 1, 1'b1, 1'b0, 1'b0, 1'b1));

    // Five-cycle stall at (2,1).
    apply(1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    check_model("reach_2_1");
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b0, 1'b1);
      compare("hold_2_1", dut_vec(), exp_vec(2, 1, 1'b1, 1'b0, 1'b0, 1'b1));
    end
    apply(1'b1, 1'b0, 1'b0);
    compare("after_stall_3_1", dut_vec(), exp_vec(3, 1, 1'b1, 1'b0, 1'b0, 1'b1));

    // start mid-frame is ignored; reset at (1,2) abandons the frame.
    apply(1'b1, 1'b1, 1'b0);
    compare("start_ignored", dut_vec(), exp_vec(0, 2, 1'b1, 1'b0, 1'b0, 1'b1));
    apply(1'b1, 1'b0, 1'b0);
    compare("reach_1_2", dut_vec(), exp_vec(1, 2, 1'b1, 1'b0, 1'b0, 1'b1));
    apply(1'b0, 1'b0, 1'b0);
    compare("mid_reset", dut_vec(), exp_vec(0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    apply(1'b1, 1'b0, 1'b0);
    compare("no_done_after_reset", dut_vec(), exp_vec(0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    apply(1'b1, 1'b1, 1'b0);
    compare("restart", dut_vec(), exp_vec(0, 0, 1'b1, 1'b1, 1'b0, 1'b1));

    // Run to the end of the frame and pulse start right after the last accept.
    for (int i = 1; i < N; i++) apply(1'b1, 1'b0, 1'b0);
    check_model("reach_last");
    apply(1'b1, 1'b0, 1'b0);
    check_model("frame_end");
    apply(1'b1, 1'b1, 1'b0);
    check_model("start_after_end");
    apply(1'b1, 1'b0, 1'b0);
    check_model("after_end");

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit s;
      bit st;
      r  = ($urandom_range(0, 299) != 0);
      s  = ($urandom_range(0, 5) == 0);
      st = ($urandom_range(0, 2) == 0);
      apply(r, s, st);
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
